wb_sram_responder: RTL

// - Pipelined Wishbone B4 slave (responder) that fronts a synchronous single-port SRAM macro.
// - Sits at the far end of the platform's DMEM / IMEM / framebuffer master ports.
// - Turns the bus requests issued there into SRAM accesses with byte enables.
// - Returns in-order ack/err responses at a fixed latency.
// - Optionally zero-fills the whole array after reset, stalling the bus while it does so.
//

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_resp_pipe.sv | 22 ++
 rtl/wb_sram_responder.sv | 68 ++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and limits for the Wishbone SRAM responder
package wb_pkg;
  localparam int MAX_READ_LATENCY = 4;
  typedef enum logic {ST_INIT, ST_ACTIVE} state_t;
  typedef struct packed {
    logic valid;
    logic err;
    logic is_read;
  } wb_resp_t;
endpackage

// File: rtl/wb_resp_pipe.sv
// wb_resp_pipe: fixed-latency delay line of bus responses with synchronous flush
module wb_resp_pipe
  import wb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic     clk_i,
  input  logic     flush,
  input  wb_resp_t req,
  output wb_resp_t rsp
);
  wb_resp_t [LATENCY-1:0] stage;
  // shift accepted requests toward the bus; a flush drops everything in flight
  always_ff @(posedge clk_i) begin
    if (flush) stage <= '0;
    else begin
      stage[0] <= req;
      for (int s = 1; s < LATENCY; s++) stage[s] <= stage[s-1];
    end
  end
  assign rsp = stage[LATENCY-1];
endmodule

// File: rtl/wb_sram_responder.sv
// wb_sram_responder: pipelined Wishbone B4 slave in front of a synchronous single-port SRAM
module wb_sram_responder
  import wb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH_LOG2   = 12,
  parameter int READ_LATENCY = 2,
  parameter int INIT_ZERO    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_W-1:0]     wb_addr_i,
  input  logic [DATA_W-1:0]     wb_wdata_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  output logic                  wb_stall_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [DATA_W-1:0]     wb_rdata_o,
  output logic                  mem_en_o,
  output logic [DATA_W/8-1:0]   mem_we_o,
  output logic [DEPTH_LOG2-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);
  state_t                state, state_nx;
  logic [DEPTH_LOG2-1:0] init_cnt;
  logic                  init, accept, in_range, hit;
  wb_resp_t              req, rsp;
  // state register; reset always restarts the zero-fill when it is enabled
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= (INIT_ZERO != 0) ? ST_INIT : ST_ACTIVE;
    else state <= state_nx;
  end
  // zero-fill address walks the whole array once, one word per cycle
  always_ff @(posedge clk_i) begin
    if (rst_i || state != ST_INIT) init_cnt <= '0;
    else init_cnt <= init_cnt + 1'b1;
  end
  // next state, address decode and SRAM/bus drive; everything is held quiet while in reset
  always_comb begin
    state_nx    = (state == ST_INIT && &init_cnt) ? ST_ACTIVE : state;
    init        = ~rst_i & (state == ST_INIT);
    accept      = ~rst_i & (state == ST_ACTIVE) & wb_cyc_i & wb_stb_i;
    in_range    = (wb_addr_i >> DEPTH_LOG2) == '0;
    hit         = accept & in_range;
    wb_stall_o  = rst_i ? (INIT_ZERO != 0) : (state == ST_INIT);
    mem_en_o    = init | hit;
    mem_we_o    = init ? '1 : (hit & wb_we_i) ? wb_sel_i : '0;
    mem_addr_o  = init ? init_cnt : accept ? wb_addr_i[DEPTH_LOG2-1:0] : '0;
    mem_wdata_o = accept ? wb_wdata_i : '0;
    req         = '{valid: accept, err: ~in_range, is_read: ~wb_we_i};
    wb_ack_o    = ~rst_i & wb_cyc_i & rsp.valid & ~rsp.err;
    wb_err_o    = ~rst_i & wb_cyc_i & rsp.valid & rsp.err;
    wb_rdata_o  = (wb_ack_o & rsp.is_read) ? mem_rdata_i : '0;
  end
  assign wb_rty_o = 1'b0;
  wb_resp_pipe #(.LATENCY(READ_LATENCY)) u_pipe (
    .clk_i (clk_i),
    .flush (~wb_cyc_i | rst_i),
    .req   (req),
    .rsp   (rsp)
  );
endmodule
